tage_update_sched: RTL and testbench

//  Buffers resolved-branch updates from NUM_DOMAINS requesters and issues them one at a time to tage_predictor.
//  Per-domain FIFOs feed a round-robin arbiter into a registered valid/ready output.

---
 rtl/tage_update_sched.sv | 202 ++++++++++++++++++++
 tb/tb_tage_update_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tage_update_sched.sv
// Per-domain update FIFOs, round-robin issue toward tage_predictor, and
// misprediction-driven aging sweeps. Define TAGE_SCHED_FLUSH_EN to add flush_i.
module tage_update_sched #(
  parameter int unsigned NUM_DOMAINS = 2,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned IDX_W       = 32,
  parameter int unsigned AGE_PERIOD  = 256
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_DOMAINS-1:0]           req_valid_i,
  output logic [NUM_DOMAINS-1:0]           req_ready_o,
  input  logic [NUM_DOMAINS*IDX_W-1:0]     req_idx_i,
  input  logic [NUM_DOMAINS-1:0]           req_taken_i,
  input  logic [NUM_DOMAINS-1:0]           req_correct_i,
  output logic                             upd_valid_o,
  input  logic                             upd_ready_i,
  output logic [IDX_W-1:0]                 upd_idx_o,
  output logic                             upd_taken_o,
  output logic                             upd_correct_o,
  output logic [$clog2(NUM_DOMAINS)-1:0]   upd_domain_o,
  output logic                             age_req_o,
  input  logic                             age_ack_i,
  output logic                             busy_o
`ifdef TAGE_SCHED_FLUSH_EN
  ,
  input  logic [NUM_DOMAINS-1:0]           flush_i
`endif
);

  localparam int unsigned DW = $clog2(NUM_DOMAINS);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(AGE_PERIOD + 1);
  localparam int unsigned EW = IDX_W + 2;

  localparam logic [AW:0]   PTR_ONE  = 1;
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(AGE_PERIOD - 1);
  localparam logic [DW-1:0] DOM_ONE  = 1;
  localparam logic [DW-1:0] DOM_LAST = DW'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    AGE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] miss_q, miss_d;
  logic [DW-1:0] rr_q;

  logic [EW-1:0] mem [NUM_DOMAINS][DEPTH];
  logic [AW:0]   wr_ptr [NUM_DOMAINS];
  logic [AW:0]   rd_ptr [NUM_DOMAINS];

  logic [NUM_DOMAINS-1:0] empty, full, avail, push, pop, flush;
  logic [DW-1:0]          grant;
  logic                   found;
  logic                   load;
  logic                   retire;
  logic [EW-1:0]          grant_entry;

`ifdef TAGE_SCHED_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = '0;
`endif

  // A flushed FIFO neither accepts a push nor offers its head to the arbiter.
  always_comb begin
    empty = '0;
    full  = '0;
    avail = '0;
    push  = '0;
    for (int unsigned d = 0; d < NUM_DOMAINS; d++) begin
      empty[d] = (wr_ptr[d] == rd_ptr[d]);
      full[d]  = (wr_ptr[d][AW] != rd_ptr[d][AW]) &&
                 (wr_ptr[d][AW-1:0] == rd_ptr[d][AW-1:0]);
      avail[d] = !empty[d] && !flush[d];
      push[d]  = req_valid_i[d] && !full[d] && !flush[d];
    end
  end

  assign req_ready_o = ~full;

  always_comb begin
    int unsigned cand;
    cand  = 0;
    found = 1'b0;
    grant = '0;
    for (int unsigned k = 0; k < NUM_DOMAINS; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= NUM_DOMAINS) cand = cand - NUM_DOMAINS;
      if (!found && avail[cand[DW-1:0]]) begin
        found = 1'b1;
        grant = cand[DW-1:0];
      end
    end
  end

  assign grant_entry = mem[grant][rd_ptr[grant][AW-1:0]];
  assign retire      = upd_valid_o && upd_ready_i;
  assign load        = (state_q == RUN) && (!upd_valid_o || upd_ready_i) && found;

  always_comb begin
    pop = '0;
    for (int unsigned d = 0; d < NUM_DOMAINS; d++) begin
      pop[d] = load && (grant == DW'(d));
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned d = 0; d < NUM_DOMAINS; d++) begin
      if (push[d]) begin
        mem[d][wr_ptr[d][AW-1:0]] <= {req_taken_i[d], req_correct_i[d],
                                      req_idx_i[d*IDX_W +: IDX_W]};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned d = 0; d < NUM_DOMAINS; d++) begin
        wr_ptr[d] <= '0;
        rd_ptr[d] <= '0;
      end
    end else begin
      for (int unsigned d = 0; d < NUM_DOMAINS; d++) begin
        if (push[d]) wr_ptr[d] <= wr_ptr[d] + PTR_ONE;
        if (flush[d]) rd_ptr[d] <= wr_ptr[d];
        else if (pop[d]) rd_ptr[d] <= rd_ptr[d] + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (load) begin
      rr_q <= (grant == DOM_LAST) ? '0 : grant + DOM_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      upd_valid_o   <= 1'b0;
      upd_idx_o     <= '0;
      upd_taken_o   <= 1'b0;
      upd_correct_o <= 1'b0;
      upd_domain_o  <= '0;
    end else if (load) begin
      upd_valid_o   <= 1'b1;
      upd_taken_o   <= grant_entry[EW-1];
      upd_correct_o <= grant_entry[EW-2];
      upd_idx_o     <= grant_entry[IDX_W-1:0];
      upd_domain_o  <= grant;
    end else if (retire) begin
      upd_valid_o   <= 1'b0;
    end
  end

  // Misses are only counted in RUN; the retire that reaches the period clears
  // the counter and starts the drain.
  always_comb begin
    state_d = state_q;
    miss_d  = miss_q;
    case (state_q)
      RUN: begin
        if (retire && !upd_correct_o) begin
          if (miss_q == CNT_LAST) begin
            miss_d  = '0;
            state_d = DRAIN;
          end else begin
            miss_d = miss_q + CNT_ONE;
          end
        end
      end
      DRAIN: begin
        if (!upd_valid_o) state_d = AGE;
      end
      AGE: begin
        if (age_ack_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
    end
  end

  assign age_req_o = (state_q == AGE);
  assign busy_o    = (~&empty) || upd_valid_o || (state_q != RUN);

endmodule

// File: tb/tb_tage_update_sched.sv
// Directed bench for tage_update_sched (AGE_PERIOD overridden to 4).
module tb_tage_update_sched;
  localparam int unsigned N  = 2;
  localparam int unsigned IW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_taken, req_correct;
  logic [N*IW-1:0] req_idx;
  logic            upd_valid, upd_ready, upd_taken, upd_correct;
  logic [IW-1:0]   upd_idx;
  logic [0:0]      upd_domain;
  logic            age_req, age_ack, busy;
`ifdef TAGE_SCHED_FLUSH_EN
  logic [N-1:0]    flush;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tage_update_sched #(
    .NUM_DOMAINS(N),
    .DEPTH(4),
    .IDX_W(IW),
    .AGE_PERIOD(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_idx_i(req_idx),
    .req_taken_i(req_taken),
    .req_correct_i(req_correct),
    .upd_valid_o(upd_valid),
    .upd_ready_i(upd_ready),
    .upd_idx_o(upd_idx),
    .upd_taken_o(upd_taken),
    .upd_correct_o(upd_correct),
    .upd_domain_o(upd_domain),
    .age_req_o(age_req),
    .age_ack_i(age_ack),
    .busy_o(busy)
`ifdef TAGE_SCHED_FLUSH_EN
    ,
    .flush_i(flush)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int unsigned d, input logic [31:0] idx, input logic tk, input logic cr);
    req_valid[d]          = 1'b1;
    req_idx[d*IW +: IW]   = idx;
    req_taken[d]          = tk;
    req_correct[d]        = cr;
  endtask

  task automatic idle();
    req_valid = '0;
  endtask

  task automatic issue(input string tag, input logic [31:0] dom, input logic [31:0] idx);
    chk({tag, "_valid"}, 32'(upd_valid), 32'd1);
    chk({tag, "_dom"}, 32'(upd_domain), dom);
    chk({tag, "_idx"}, upd_idx, idx);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_idx = '0; req_taken = '0; req_correct = '0;
    upd_ready = 1'b0; age_ack = 1'b0;
`ifdef TAGE_SCHED_FLUSH_EN
    flush = '0;
`endif
    tick(); tick();
    chk("rst_valid", 32'(upd_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd3);
    chk("rst_age", 32'(age_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_idx", upd_idx, 32'd0);
    rst = 1'b0;

    // Round robin: 3 entries per domain, sink always ready.
    upd_ready = 1'b1;
    push(0, 32'h100, 1'b1, 1'b1);
    push(1, 32'h200, 1'b0, 1'b1);
    tick();
    chk("rr_lat0", 32'(upd_valid), 32'd0);
    chk("rr_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 6; k++) begin
      if (k < 2) begin
        push(0, 32'h101 + 32'(k), 1'b1, 1'b1);
        push(1, 32'h201 + 32'(k), 1'b0, 1'b1);
      end else begin
        idle();
      end
      tick();
      issue("rr", 32'(k % 2), (k % 2 == 1) ? 32'h200 + 32'(k / 2) : 32'h100 + 32'(k / 2));
      chk("rr_taken", 32'(upd_taken), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    idle();
    tick();
    chk("rr_end_valid", 32'(upd_valid), 32'd0);
    chk("rr_end_busy", 32'(busy), 32'd0);

    // Backpressure: output held while domain 0 fills its FIFO.
    upd_ready = 1'b0;
    push(0, 32'h300, 1'b1, 1'b1);
    tick();
    idle();
    tick();
    issue("bp_first", 32'd0, 32'h300);
    for (int i = 0; i < 4; i++) begin
      push(0, 32'h301 + 32'(i), 1'b1, 1'b1);
      tick();
      chk("bp_stable", upd_idx, 32'h300);
      chk("bp_ready0", 32'(req_ready[0]), (i == 3) ? 32'd0 : 32'd1);
    end
    push(0, 32'h305, 1'b1, 1'b1);
    tick();
    chk("bp_stable5", upd_idx, 32'h300);
    chk("bp_full", 32'(req_ready[0]), 32'd0);
    idle();
    upd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      issue("bp_drain", 32'd0, 32'h301 + 32'(i));
    end
    tick();
    chk("bp_dropped", 32'(upd_valid), 32'd0);

    // Full + pop: push into a full FIFO is rejected even while it pops.
    upd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(1, 32'h400 + 32'(i), 1'b0, 1'b1);
      tick();
    end
    chk("fp_full", 32'(req_ready), 32'd1);
    issue("fp_held", 32'd1, 32'h400);
    push(1, 32'h405, 1'b0, 1'b1);
    upd_ready = 1'b1;
    tick();
    issue("fp_pop", 32'd1, 32'h401);
    chk("fp_ready", 32'(req_ready), 32'd3);
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      issue("fp_drain", 32'd1, 32'h402 + 32'(i));
    end
    tick();
    chk("fp_count3", 32'(upd_valid), 32'd0);
    chk("fp_busy", 32'(busy), 32'd0);

    // Aging: four mispredicted retires start a drain and an aging request.
    for (int i = 0; i < 4; i++) begin
      push(0, 32'h500 + 32'(i), 1'b1, 1'b0);
      tick();
    end
    idle();
    tick();
    issue("ag_last", 32'd0, 32'h503);
    chk("ag_noreq", 32'(age_req), 32'd0);
    tick();
    chk("ag_drain_valid", 32'(upd_valid), 32'd0);
    chk("ag_drain_req", 32'(age_req), 32'd0);
    chk("ag_drain_busy", 32'(busy), 32'd1);
    push(1, 32'h510, 1'b1, 1'b1);
    tick();
    idle();
    chk("ag_req", 32'(age_req), 32'd1);
    chk("ag_req_valid", 32'(upd_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ag_hold_req", 32'(age_req), 32'd1);
      chk("ag_hold_valid", 32'(upd_valid), 32'd0);
    end
    age_ack = 1'b1;
    tick();
    age_ack = 1'b0;
    chk("ag_ack_req", 32'(age_req), 32'd0);
    chk("ag_ack_valid", 32'(upd_valid), 32'd0);
    tick();
    issue("ag_resume", 32'd1, 32'h510);
    tick();
    chk("ag_done_valid", 32'(upd_valid), 32'd0);
    chk("ag_done_busy", 32'(busy), 32'd0);

    // Reset mid-traffic discards everything immediately.
    upd_ready = 1'b0;
    push(0, 32'h800, 1'b1, 1'b1);
    push(1, 32'h900, 1'b1, 1'b1);
    tick();
    tick();
    idle();
    chk("mr_pre_valid", 32'(upd_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_valid", 32'(upd_valid), 32'd0);
    chk("mr_ready", 32'(req_ready), 32'd3);
    chk("mr_age", 32'(age_req), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_idx", upd_idx, 32'd0);
    tick();
    rst = 1'b0;
    upd_ready = 1'b1;
    tick();
    tick();
    chk("mr_empty", 32'(upd_valid), 32'd0);
    chk("mr_idle", 32'(busy), 32'd0);

`ifdef TAGE_SCHED_FLUSH_EN
    upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(0, 32'h600 + 32'(i), 1'b1, 1'b1);
      tick();
    end
    idle();
    push(1, 32'h700, 1'b0, 1'b1);
    tick();
    push(0, 32'h604, 1'b1, 1'b1);
    push(1, 32'h701, 1'b0, 1'b1);
    flush = 2'b01;
    tick();
    flush = '0;
    idle();
    chk("fl_ready", 32'(req_ready), 32'd3);
    issue("fl_reg", 32'd0, 32'h600);
    upd_ready = 1'b1;
    tick();
    issue("fl_d1a", 32'd1, 32'h700);
    tick();
    issue("fl_d1b", 32'd1, 32'h701);
    tick();
    chk("fl_end", 32'(upd_valid), 32'd0);
    chk("fl_busy", 32'(busy), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
